// File: rtl/register_bank_pkg.sv
// Shared write-operation encodings and the next-value rule for register_bank.
// Used by the top whether or not REGISTER_BANK_BYPASS_EN is defined.
package register_bank_pkg;

  localparam logic [1:0] OP_LOAD      = 2'b00;
  localparam logic [1:0] OP_CLEAR     = 2'b01;
  localparam logic [1:0] OP_INVERT    = 2'b10;
  localparam logic [1:0] OP_INCREMENT = 2'b11;

  // Widest word the helper handles; callers zero-extend in and truncate out,
  // which keeps INCREMENT modulo 2^WIDTH because the carry lands above WIDTH.
  localparam int MAX_WIDTH = 1024;

  function automatic logic [MAX_WIDTH-1:0] next_value(
    input logic [1:0]           op,
    input logic [MAX_WIDTH-1:0] cur,
    input logic [MAX_WIDTH-1:0] data
  );
    logic [MAX_WIDTH-1:0] res;
    case (op)
      OP_LOAD:   res = data;
      OP_CLEAR:  res = '0;
      OP_INVERT: res = ~cur;
      default:   res = cur + MAX_WIDTH'(1);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/register_cell.sv
// One WIDTH-bit storage word with load enable and asynchronous active-high clear.
module register_cell #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/register_bank.sv
// DEPTH x WIDTH register bank: one write port (load/clear/invert/increment), two
// combinational read ports. Define REGISTER_BANK_BYPASS_EN for write-through reads.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [1:0]       wop,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] D,
  input  logic [AW-1:0]    raddr_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] Q_a,
  output logic [WIDTH-1:0] Q_comp_a,
  output logic [WIDTH-1:0] Q_b,
  output logic [WIDTH-1:0] Q_comp_b,
  output logic             wr_ack
);

  logic [WIDTH-1:0] words [DEPTH];
  logic [DEPTH-1:0] wr_en;
  logic             wr_valid;
  logic [WIDTH-1:0] cur_word;
  logic [WIDTH-1:0] next_word;
  logic [WIDTH-1:0] read_a;
  logic [WIDTH-1:0] read_b;

  // An address beyond DEPTH matches no decoder output, so it is discarded here
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cell
      assign wr_en[gi] = we && (waddr == AW'(gi));

      register_cell #(.WIDTH(WIDTH)) u_cell (
        .clk (clk),
        .rst (rst),
        .en  (wr_en[gi]),
        .d   (next_word),
        .q   (words[gi])
      );
    end
  endgenerate

  assign wr_valid = |wr_en;

  // Out-of-range read addresses fall through to the zero default
  always_comb begin
    cur_word = '0;
    read_a   = '0;
    read_b   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (waddr == AW'(i))
        cur_word = words[i];
      if (raddr_a == AW'(i))
        read_a = words[i];
      if (raddr_b == AW'(i))
        read_b = words[i];
    end
  end

  assign next_word = WIDTH'(next_value(wop, MAX_WIDTH'(cur_word), MAX_WIDTH'(D)));

`ifdef REGISTER_BANK_BYPASS_EN
  assign Q_a = (wr_valid && (waddr == raddr_a)) ? next_word : read_a;
  assign Q_b = (wr_valid && (waddr == raddr_b)) ? next_word : read_b;
`else
  assign Q_a = read_a;
  assign Q_b = read_b;
`endif

  assign Q_comp_a = ~Q_a;
  assign Q_comp_b = ~Q_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wr_ack <= 1'b0;
    else
      wr_ack <= wr_valid;
  end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: a DEPTH=8 and a DEPTH=6 instance share
// stimulus and are compared against array-based reference models.
module tb_register_bank;
  import register_bank_pkg::*;

  logic        clk;
  logic        rst;
  logic        we;
  logic [1:0]  wop;
  logic [2:0]  waddr;
  logic [31:0] D;
  logic [2:0]  raddr_a;
  logic [2:0]  raddr_b;

  logic [31:0] q_a8, qc_a8, q_b8, qc_b8;
  logic [31:0] q_a6, qc_a6, q_b6, qc_b6;
  logic        ack8, ack6;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] m8 [8];
  logic [31:0] m6 [6];
  logic        ack8_e, ack6_e;

  register_bank #(.WIDTH(32), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .we(we), .wop(wop), .waddr(waddr), .D(D),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .Q_a(q_a8), .Q_comp_a(qc_a8), .Q_b(q_b8), .Q_comp_b(qc_b8), .wr_ack(ack8)
  );

  register_bank #(.WIDTH(32), .DEPTH(6)) dut6 (
    .clk(clk), .rst(rst), .we(we), .wop(wop), .waddr(waddr), .D(D),
    .raddr_a(raddr_a), .raddr_b(raddr_b),
    .Q_a(q_a6), .Q_comp_a(qc_a6), .Q_b(q_b6), .Q_comp_b(qc_b6), .wr_ack(ack6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] calc(input logic [1:0] op, input logic [31:0] cur,
                                       input logic [31:0] d);
    case (op)
      2'd0:    return d;
      2'd1:    return 32'd0;
      2'd2:    return ~cur;
      default: return cur + 32'd1;
    endcase
  endfunction

  function automatic logic [31:0] exp8(input logic [2:0] ra);
    logic [31:0] v;
    v = m8[ra];
`ifdef REGISTER_BANK_BYPASS_EN
    if (we && waddr == ra) v = calc(wop, m8[waddr], D);
`endif
    return v;
  endfunction

  function automatic logic [31:0] exp6(input logic [2:0] ra);
    logic [31:0] v;
    if (ra >= 6) return 32'd0;
    v = m6[ra];
`ifdef REGISTER_BANK_BYPASS_EN
    if (we && waddr < 6 && waddr == ra) v = calc(wop, m6[waddr], D);
`endif
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m8[i] = 32'd0;
    for (int i = 0; i < 6; i++) m6[i] = 32'd0;
    ack8_e = 1'b0;
    ack6_e = 1'b0;
  endtask

  task automatic drive(input logic w, input logic [1:0] op, input logic [2:0] a,
                       input logic [31:0] d, input logic [2:0] ra, input logic [2:0] rb);
    @(negedge clk);
    we = w; wop = op; waddr = a; D = d; raddr_a = ra; raddr_b = rb;
    #1;
  endtask

  task automatic edge_update();
    @(posedge clk);
    if (rst) begin
      ack8_e = 1'b0;
      ack6_e = 1'b0;
    end else begin
      ack8_e = we;
      ack6_e = we && (waddr < 6);
      if (ack8_e) m8[waddr] = calc(wop, m8[waddr], D);
      if (ack6_e) m6[waddr] = calc(wop, m6[waddr], D);
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int a = 0; a < 8; a++) begin
      drive(1'b1, OP_LOAD, a[2:0], 32'h12345678, a[2:0], 3'(7 - a));
      edge_update();
    end
    vectors++;
    if (ack8 !== 1'b1) begin
      miscompares++; $display("FAIL reset_pre_ack got=%b want=1", ack8);
    end
    rst = 1'b1; we = 1'b0;
    model_clear();
    #1;
    vectors++;
    if ({q_a8, qc_a8, q_b8, qc_b8, ack8} !== {32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async8 got=%h/%h/%h/%h ack=%b want=0/ffffffff/0/ffffffff ack=0",
               q_a8, qc_a8, q_b8, qc_b8, ack8);
    end
    vectors++;
    if ({q_a6, qc_a6, ack6} !== {32'd0, 32'hFFFFFFFF, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async6 got=%h/%h ack=%b want=0/ffffffff ack=0", q_a6, qc_a6, ack6);
    end
    #1 rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, OP_LOAD, 3'd0, 32'd0, a[2:0], 3'(7 - a));
      vectors++;
      if ({q_a8, q_b8, q_a6} !== {exp8(raddr_a), exp8(raddr_b), exp6(raddr_a)}) begin
        miscompares++;
        $display("FAIL reset_erased addr=%0d got=%h/%h/%h want=%h/%h/%h", a, q_a8, q_b8, q_a6,
                 exp8(raddr_a), exp8(raddr_b), exp6(raddr_a));
      end
    end
  endtask

  task automatic test_load_invert();
    drive(1'b1, OP_LOAD, 3'd3, 32'hAAAAAAAA, 3'd3, 3'd0);
    edge_update();
    vectors++;
    if ({q_a8, qc_a8, ack8} !== {exp8(3'd3), ~exp8(3'd3), ack8_e}) begin
      miscompares++;
      $display("FAIL load got=%h/%h ack=%b want=%h/%h ack=%b", q_a8, qc_a8, ack8,
               exp8(3'd3), ~exp8(3'd3), ack8_e);
    end
    drive(1'b1, OP_INVERT, 3'd3, $urandom, 3'd3, 3'd0);
    edge_update();
    vectors++;
    if ({q_a8, qc_a8, ack8} !== {exp8(3'd3), ~exp8(3'd3), 1'b1}) begin
      miscompares++;
      $display("FAIL invert got=%h/%h ack=%b want=%h/%h ack=1", q_a8, qc_a8, ack8,
               exp8(3'd3), ~exp8(3'd3));
    end
    drive(1'b0, OP_INVERT, 3'd3, 32'd0, 3'd3, 3'd0);
    edge_update();
    vectors++;
    if ({q_a8, ack8} !== {32'h55555555, 1'b0}) begin
      miscompares++;
      $display("FAIL invert_hold got=%h ack=%b want=55555555 ack=0", q_a8, ack8);
    end
  endtask

  task automatic test_increment_wrap();
    drive(1'b1, OP_LOAD, 3'd7, 32'hFFFFFFFF, 3'd7, 3'd7);
    edge_update();
    drive(1'b1, OP_INCREMENT, 3'd7, $urandom, 3'd7, 3'd7);
    edge_update();
    vectors++;
    if ({q_a8, qc_a8, q_b8} !== {exp8(3'd7), ~exp8(3'd7), exp8(3'd7)}) begin
      miscompares++;
      $display("FAIL inc_wrap got=%h/%h/%h want=%h/%h", q_a8, qc_a8, q_b8, exp8(3'd7), ~exp8(3'd7));
    end
    vectors++;
    if ({q_a6, qc_a6, ack6, ack8} !== {32'd0, 32'hFFFFFFFF, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL inc_range6 got=%h/%h ack6=%b ack8=%b want=0/ffffffff ack6=0 ack8=1",
               q_a6, qc_a6, ack6, ack8);
    end
    drive(1'b0, OP_INCREMENT, 3'd7, 32'd0, 3'd7, 3'd7);
    edge_update();
    drive(1'b1, OP_INCREMENT, 3'd7, 32'd0, 3'd7, 3'd7);
    edge_update();
    drive(1'b0, OP_INCREMENT, 3'd7, 32'd0, 3'd7, 3'd7);
    vectors++;
    if ({q_a8, qc_a8} !== {32'h00000001, 32'hFFFFFFFE}) begin
      miscompares++;
      $display("FAIL inc_after_wrap got=%h/%h want=00000001/fffffffe", q_a8, qc_a8);
    end
  endtask

  task automatic test_enable_range();
    drive(1'b1, OP_LOAD, 3'd1, 32'h0F0F0F0F, 3'd1, 3'd1);
    edge_update();
    drive(1'b0, OP_LOAD, 3'd1, 32'h80000801, 3'd1, 3'd1);
    edge_update();
    vectors++;
    if ({q_a8, q_a6, ack8, ack6} !== {exp8(3'd1), exp6(3'd1), 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL we_low got=%h/%h ack=%b%b want=%h/%h ack=00", q_a8, q_a6, ack8, ack6,
               exp8(3'd1), exp6(3'd1));
    end
    drive(1'b1, OP_LOAD, 3'd7, 32'hDEADBEEF, 3'd7, 3'd6);
    edge_update();
    vectors++;
    if ({ack6, ack8, q_a6, qc_a6, q_b6} !== {1'b0, 1'b1, 32'd0, 32'hFFFFFFFF, 32'd0}) begin
      miscompares++;
      $display("FAIL oor_write6 ack6=%b ack8=%b got=%h/%h/%h want ack6=0 ack8=1 0/ffffffff/0",
               ack6, ack8, q_a6, qc_a6, q_b6);
    end
    for (int a = 0; a < 6; a++) begin
      drive(1'b0, OP_LOAD, 3'd0, 32'd0, a[2:0], a[2:0]);
      vectors++;
      if (q_a6 !== exp6(raddr_a)) begin
        miscompares++;
        $display("FAIL oor_untouched6 addr=%0d got=%h want=%h", a, q_a6, exp6(raddr_a));
      end
    end
  endtask

  task automatic test_dual_read_clear();
    drive(1'b1, OP_LOAD, 3'd2, 32'h0000F00F, 3'd2, 3'd5);
    edge_update();
    drive(1'b1, OP_LOAD, 3'd5, 32'h80000001, 3'd2, 3'd5);
    edge_update();
    drive(1'b0, OP_LOAD, 3'd0, 32'd0, 3'd2, 3'd5);
    vectors++;
    if ({q_a8, qc_a8, q_b8, qc_b8} !== {32'h0000F00F, 32'hFFFF0FF0, 32'h80000001, 32'h7FFFFFFE}) begin
      miscompares++;
      $display("FAIL dual_read got=%h/%h/%h/%h want=0000f00f/ffff0ff0/80000001/7ffffffe",
               q_a8, qc_a8, q_b8, qc_b8);
    end
    drive(1'b1, OP_CLEAR, 3'd5, $urandom, 3'd2, 3'd5);
    edge_update();
    vectors++;
    if ({q_a8, q_b8, qc_b8, q_a6, q_b6} !== {exp8(3'd2), exp8(3'd5), ~exp8(3'd5), exp6(3'd2), exp6(3'd5)}) begin
      miscompares++;
      $display("FAIL clear got=%h/%h/%h/%h/%h want=%h/%h/%h/%h/%h", q_a8, q_b8, qc_b8, q_a6, q_b6,
               exp8(3'd2), exp8(3'd5), ~exp8(3'd5), exp6(3'd2), exp6(3'd5));
    end
  endtask

  task automatic test_read_during_write();
    logic [31:0] pre_want;
`ifdef REGISTER_BANK_BYPASS_EN
    pre_want = 32'h22222222;
`else
    pre_want = 32'h11111111;
`endif
    drive(1'b1, OP_LOAD, 3'd4, 32'h11111111, 3'd4, 3'd4);
    edge_update();
    drive(1'b1, OP_LOAD, 3'd4, 32'h22222222, 3'd4, 3'd4);
    vectors++;
    if ({q_a8, qc_a8, q_b6} !== {pre_want, ~pre_want, pre_want}) begin
      miscompares++;
      $display("FAIL rdw_before got=%h/%h/%h want=%h/%h/%h", q_a8, qc_a8, q_b6, pre_want, ~pre_want, pre_want);
    end
    edge_update();
    vectors++;
    if ({q_a8, q_b6} !== {32'h22222222, 32'h22222222}) begin
      miscompares++;
      $display("FAIL rdw_after got=%h/%h want=22222222", q_a8, q_b6);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    for (int n = 0; n < 300; n++) begin
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), d,
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 31) == 0) begin
        rst = 1'b1;
        model_clear();
        edge_update();
        rst = 1'b0;
        #1;
      end else begin
        vectors++;
        if ({q_a8, qc_a8, q_b8, qc_b8} !== {exp8(raddr_a), ~exp8(raddr_a), exp8(raddr_b), ~exp8(raddr_b)}) begin
          miscompares++;
          $display("FAIL rand_pre8 n=%0d got=%h/%h/%h/%h want=%h/%h", n, q_a8, qc_a8, q_b8, qc_b8,
                   exp8(raddr_a), exp8(raddr_b));
        end
        edge_update();
      end
      vectors++;
      if ({ack8, ack6} !== {ack8_e, ack6_e}) begin
        miscompares++;
        $display("FAIL rand_ack n=%0d got=%b%b want=%b%b", n, ack8, ack6, ack8_e, ack6_e);
      end
      vectors++;
      if ({q_a8, q_b8, q_a6, qc_a6, q_b6, qc_b6} !==
          {exp8(raddr_a), exp8(raddr_b), exp6(raddr_a), ~exp6(raddr_a), exp6(raddr_b), ~exp6(raddr_b)}) begin
        miscompares++;
        $display("FAIL rand_post n=%0d ra=%0d rb=%0d got=%h/%h/%h/%h want=%h/%h/%h/%h", n, raddr_a, raddr_b,
                 q_a8, q_b8, q_a6, q_b6, exp8(raddr_a), exp8(raddr_b), exp6(raddr_a), exp6(raddr_b));
      end
    end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wop = OP_LOAD; waddr = '0; D = '0; raddr_a = '0; raddr_b = '0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_load_invert();
    test_increment_wrap();
    test_enable_range();
    test_dual_read_clear();
    test_read_during_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d vectors", vectors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/register_bank.md
# register_bank

Parametrised multi-register storage block, successor to the single 32-bit enable register. It holds DEPTH words of WIDTH bits and supports one write port with four write operations: load, clear, invert and increment. It has two independent combinational read ports, each returning the word and its bitwise complement. It sits between the datapath and the control unit as the general-purpose register storage of the design.

## Interface
Parameters:
- WIDTH, 32: bits per word (≥1).
- DEPTH, 8: number of words (≥2); need not be a power of two.
- AW, $clog2(DEPTH): address width (derived; not overridden).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable for the write port.
- wop  input  2  write operation: 00 LOAD, 01 CLEAR, 10 INVERT, 11 INCREMENT.
- waddr  input  AW  write address.
- D  input  WIDTH  write data (used only by LOAD).
- raddr_a  input  AW  read address, port A.
- raddr_b  input  AW  read address, port B.
- Q_a  output  WIDTH  word at raddr_a.
- Q_comp_a  output  WIDTH  ~Q_a.
- Q_b  output  WIDTH  word at raddr_b.
- Q_comp_b  output  WIDTH  ~Q_b.
- wr_ack  output  1  registered; high for one cycle after an accepted write.

## Operation
- Reset:
  - All words clear to 0 immediately, independent of clk.
  - Q_* = 0, Q_comp_* = all ones, wr_ack = 0.
- A write is accepted at a rising edge when we=1, rst=0 and waddr < DEPTH.
- Next value of R[waddr], by wop:
  - LOAD: D.
  - CLEAR: 0.
  - INVERT: ~R[waddr].
  - INCREMENT: R[waddr]+1 modulo 2^WIDTH. All-ones wraps to 0; no carry out.
- we=0: all words hold; D, wop and waddr are ignored.
- Out-of-range address (waddr ≥ DEPTH):
  - Write is discarded and wr_ack stays 0.
  - A read at raddr ≥ DEPTH returns Q=0, Q_comp=all ones.
- Read ports are combinational and fully independent. Both ports may address the same word.
- Q_comp_x is always exactly ~Q_x. No state is kept for the complement.
- wr_ack = 1 in the cycle following each accepted write, else 0. Back-to-back writes keep it high.

## Timing
- Write latency: the new value is visible on read ports one rising edge after the write is presented (no bypass).
- Read latency: 0 cycles, combinational from raddr and stored state.
- Read-during-write to the same address, without bypass: the read returns the old value until the edge.
- Reset asserted mid-operation: an in-flight write is lost. Reset has priority over any write at the same edge.
- After rst deasserts, the first accepted write occurs at the first rising edge with we=1.

## Configuration
- Macro REGISTER_BANK_BYPASS_EN.
- Defined: when we=1 and waddr is valid and equal to raddr_x, Q_x shows the computed next value in the same cycle (write-through forwarding), and Q_comp_x shows its complement. Stored-state timing and wr_ack are unchanged.
- Undefined: reads show stored state only, as in Timing.

## Structure
- Package register_bank_pkg holds:
  - the 2-bit wop encodings as named constants (OP_LOAD, OP_CLEAR, OP_INVERT, OP_INCREMENT);
  - a function computing the next-value from (op, current word, D).
- Sub-module register_cell: one WIDTH-bit register with enable and async active-high reset. It is instantiated DEPTH times in a generate loop.
- Per-word enables come from the address decode. Read muxes and the range check live in register_bank.

## Test plan
WIDTH=32, DEPTH=8 unless noted.
- Reset: pulse rst between clock edges -> all Q_a/Q_b = 0x00000000, Q_comp = 0xFFFFFFFF, wr_ack=0 immediately. Earlier writes of 0x12345678 are erased.
- LOAD/INVERT: LOAD 0xAAAAAAAA to addr 3, then INVERT addr 3 -> port A shows 0xAAAAAAAA then 0x55555555, Q_comp_a the complement, wr_ack high two cycles.
- INCREMENT wrap: LOAD 0xFFFFFFFF to addr 7, INCREMENT -> Q=0x00000000, Q_comp=0xFFFFFFFF. INCREMENT again -> 0x00000001.
- Enable/range: we=0 with D=0x80000801 to addr 1 -> addr 1 unchanged. DEPTH=6, write to addr 7 -> no word changes, wr_ack=0, read addr 7 returns 0.
- Dual read/CLEAR: addr 2=0x0000F00F, addr 5=0x80000001, raddr_a=2, raddr_b=5 -> both correct simultaneously. CLEAR addr 5 -> Q_b=0, Q_a unchanged.
- Read-during-write: addr 4=0x11111111, LOAD 0x22222222 with raddr_a=4 -> before the edge Q_a=0x11111111 without REGISTER_BANK_BYPASS_EN and 0x22222222 with it. After the edge both builds show 0x22222222.
